// File: rtl/mux2_pkg.sv
// ============================================================================
// Module  : mux2_pkg
// Brief   : Shared width, state and select encodings for the mux2 slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux2_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Select values understood by multiplexer2.s
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam logic [7:0] CNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == CNT_MAX) ? val : val + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Combinational two-way round-robin grant; history kept by parent.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      gnt_idx   = 1'b0;
      if (valid0 && valid1) begin
         // Contention goes to whichever channel lost last time
         gnt_idx = ~last_grant;
      end else if (valid1) begin
         gnt_idx = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux2_arbiter.sv
// ============================================================================
// Module  : mux2_arbiter
// Brief   : Round-robin arbiter + operand register feeding multiplexer2.
//           Optional grant counters enabled by MUX2_ARB_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux2_arbiter
   import mux2_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             s,
   output logic             out_valid,
   input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [7:0]       grant_cnt0,
   output logic [7:0]       grant_cnt1
`endif
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_s;
   logic             r_last_grant;
   logic             w_load;
   logic             w_gnt_valid;
   logic             w_gnt_idx;
   logic             w_take0;
   logic             w_take1;

   // The holding register can be refilled whenever it is empty or draining
   assign w_load = (r_state == ST_EMPTY) || out_ready;

   rr_arb2 u_rr_arb2 (
      .valid0     (in0_valid),
      .valid1     (in1_valid),
      .last_grant (r_last_grant),
      .gnt_valid  (w_gnt_valid),
      .gnt_idx    (w_gnt_idx)
   );

   assign w_take0   = w_load && w_gnt_valid && (w_gnt_idx == 1'b0);
   assign w_take1   = w_load && w_gnt_valid && (w_gnt_idx == 1'b1);
   assign in0_ready = w_take0;
   assign in1_ready = w_take1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load) begin
         w_state_nxt = w_gnt_valid ? ST_FULL : ST_EMPTY;
      end
   end

   always_comb begin
      out_valid = (r_state == ST_FULL);
   end

   // Only the granted operand moves; the other keeps its last word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_s          <= SEL_A;
         r_last_grant <= 1'b1;
      end else if (w_take0) begin
         r_a          <= in0_data;
         r_s          <= SEL_A;
         r_last_grant <= 1'b0;
      end else if (w_take1) begin
         r_b          <= in1_data;
         r_s          <= SEL_B;
         r_last_grant <= 1'b1;
      end
   end

   assign a = r_a;
   assign b = r_b;
   assign s = r_s;

`ifdef MUX2_ARB_STATS_EN
   logic [7:0] r_cnt0;
   logic [7:0] r_cnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt0 <= 8'd0;
         r_cnt1 <= 8'd0;
      end else begin
         if (w_take0) r_cnt0 <= sat_inc8(r_cnt0);
         if (w_take1) r_cnt1 <= sat_inc8(r_cnt1);
      end
   end

   assign grant_cnt0 = r_cnt0;
   assign grant_cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-channel round-robin arbiter and operand register that sits directly upstream of `multiplexer2`. It accepts 4-bit words from two independent valid/ready sources, picks one per cycle, and registers the word into the `a` or `b` operand. It drives the select `s` so that `multiplexer2.y` presents the granted word, and holds the result until the downstream consumer accepts it.

## Interface
- `WIDTH`, 4, operand width; must match `multiplexer2`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in0_valid`  input  1  channel 0 has a word.
- `in0_data`  input  WIDTH  channel 0 word.
- `in0_ready`  output  1  channel 0 word accepted this cycle.
- `in1_valid`  input  1  channel 1 has a word.
- `in1_data`  input  WIDTH  channel 1 word.
- `in1_ready`  output  1  channel 1 word accepted this cycle.
- `a`  output  WIDTH  to `multiplexer2.a`; channel 0 operand register.
- `b`  output  WIDTH  to `multiplexer2.b`; channel 1 operand register.
- `s`  output  1  to `multiplexer2.s`; 0 routes `a`, 1 routes `b`.
- `out_valid`  output  1  `y` of the downstream mux is valid.
- `out_ready`  input  1  downstream consumer accepts `y`.

## Operation
- Two states:
  - EMPTY: no word held.
  - FULL: word held, `out_valid`=1.
- `load` = (state==EMPTY) || `out_ready`. Arbitration happens only when `load`=1.
- Grant rules:
  - Only one channel valid: that channel is granted.
  - Both valid: the channel not granted last time is granted (round robin via `last_grant` register).
  - Neither valid: no grant.
- `inN_ready` = `load` && (grant==N). This is combinational; at most one ready is high per cycle.
- On a grant to channel 0: `a`←`in0_data`, `s`←0, `b` holds, `last_grant`←0.
- On a grant to channel 1: `b`←`in1_data`, `s`←1, `a` holds, `last_grant`←1.
- Transitions:
  - Grant → FULL.
  - `load` without a grant → EMPTY (`out_valid`←0).
  - No `load` → state, `a`, `b`, `s` hold.
- Reset values:
  - `a`=0, `b`=0, `s`=0, `out_valid`=0, state EMPTY.
  - `last_grant`=1, so channel 0 wins the first contention.
- Reset mid-transfer: the held word is discarded and all outputs return to reset values immediately (asynchronous).

## Timing
- Latency: 1 cycle. A word accepted at edge N appears on `a`/`b`/`s` with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle while `out_ready`=1. The output register is replaced on the same edge it drains, so there are no bubbles.
- Backpressure: while FULL and `out_ready`=0, both readies are 0 and `a`, `b`, `s` are stable. This satisfies the downstream hold rule.
- Simultaneous drain and accept: the old word is consumed and the new word is loaded on the same edge.
- Fairness: with both channels continuously valid and `out_ready`=1, grants alternate 0,1,0,1….
- `inN_ready` must not depend on `inN_valid` of the same channel beyond arbitration. Sources must not wait on ready before asserting valid.

## Configuration
- Macro: `MUX2_ARB_STATS_EN`.
- Defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1` (8 bits each).
  - Each counter increments on every grant to its channel and saturates at 255.
  - Both counters are cleared by `rst`.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `mux2_pkg`:
  - Holds the default `WIDTH`.
  - Holds the state encoding (EMPTY=0, FULL=1).
  - Holds the select encoding constants `SEL_A`=0 and `SEL_B`=1, shared with `multiplexer2`.
- Sub-module `rr_arb2`:
  - Purely combinational round-robin grant from two valids plus `last_grant`.
  - Outputs `gnt_valid` and `gnt_idx`.
  - The `last_grant` register stays in the parent.

## Test plan
- Reset: assert `rst` mid-cycle → `a`=0, `b`=0, `s`=0, `out_valid`=0 immediately; `last_grant`=1.
- Single channel: `in1_valid`=1, `in1_data`=4'h2, `out_ready`=1 → `in1_ready`=1. Next cycle `b`=4'h2, `s`=1, `out_valid`=1; `a` unchanged.
- Contention: both valid continuously (`in0_data`=4'h1, `in1_data`=4'h2), `out_ready`=1 → `s` sequence 0,1,0,1 and `y` sequence 1,2,1,2 through `multiplexer2`.
- Backpressure: FULL with `s`=0, `a`=4'h1, `out_ready`=0 for 3 cycles while both sources are valid → both readies 0, outputs stable. On release, channel 1 is granted next.
- Drain to empty: FULL, `out_ready`=1, no valids → `out_valid`=0 next cycle, `a`/`b`/`s` hold their values.
- With `MUX2_ARB_STATS_EN`: 300 consecutive channel-0 grants → `grant_cnt0`=255, `grant_cnt1`=0.
